// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared constants for the MIPS32 pipeline control blocks.
// Holds the hazard FSM state encoding, the register-zero address, the default
// register-address width and the packed control-word patterns driven by
// pipeline_hazard_ctrl.
package mips_pipe_pkg;

    localparam int SIZE_ADDR = 5;

    localparam logic [SIZE_ADDR-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    // Control word: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //                ex_mem_en, mem_wb_en, mem_wb_bubble}
    localparam logic [7:0] CTL_RUN    = 8'b1101_0110;
    localparam logic [7:0] CTL_BRANCH = 8'b1111_1110;
    localparam logic [7:0] CTL_LOAD   = 8'b0001_1110;
    localparam logic [7:0] CTL_MSTALL = 8'b0000_0011;
    localparam logic [7:0] CTL_FREEZE = 8'b0000_0001;
    localparam logic [7:0] CTL_RESET  = 8'b0010_1001;

endpackage

// File: rtl/hazard_stall_counter.sv
// hazard_stall_counter: saturating 32-bit event counter.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low clear
//   inc   - count one event this cycle
//   count - running total, holds at 0xFFFFFFFF
module hazard_stall_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS32 pipeline.
// Optional feature macro: HAZARD_STATS_EN (adds hazard event counters).
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   id_rs, id_rt                - source registers of the ID instruction
//   ex_mem_read, ex_rt          - load in EX and its destination
//   branch_taken                - branch resolved taken in EX
//   mem_req, mem_ready          - data-memory access in MEM and its completion
//   pc_en .. mem_wb_bubble      - pipeline register enables / flushes
//   mem_err                     - sticky memory-timeout error
//   state_o                     - current FSM state
//   cnt_load_stall, cnt_mem_stall, cnt_flush - event counters (HAZARD_STATS_EN)
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int SIZE_ADDR   = mips_pipe_pkg::SIZE_ADDR,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SIZE_ADDR-1:0] id_rs,
    input  logic [SIZE_ADDR-1:0] id_rt,
    input  logic                 ex_mem_read,
    input  logic [SIZE_ADDR-1:0] ex_rt,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 mem_wb_bubble,
    output logic                 mem_err,
`ifdef HAZARD_STATS_EN
    output logic [31:0]          cnt_load_stall,
    output logic [31:0]          cnt_mem_stall,
    output logic [31:0]          cnt_flush,
`endif
    output logic [1:0]           state_o
);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             err_d;
    logic [7:0]       ctl;
    logic             mem_stall, load_use;

    assign mem_stall = mem_req && !mem_ready;
    assign load_use  = ex_mem_read && ex_rt != SIZE_ADDR'(REG_ZERO) &&
                       (ex_rt == id_rs || ex_rt == id_rt);

    assign {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
            ex_mem_en, mem_wb_en, mem_wb_bubble} = ctl;
    assign state_o = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            mem_err <= err_d;
        end
    end

    // A dropped mem_req while waiting is treated as completion.
    always_comb begin
        ctl     = CTL_RUN;
        state_d = state;
        cnt_d   = cnt;
        err_d   = mem_err;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    ctl     = CTL_MSTALL;
                    state_d = ST_MEM_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (branch_taken)
                    ctl = CTL_BRANCH;
                else if (load_use)
                    ctl = CTL_LOAD;
            end
            ST_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    ctl = CTL_MSTALL;
                    if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else
                        cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_ERROR: ctl = CTL_FREEZE;
            default: begin
                ctl     = CTL_FREEZE;
                state_d = ST_RUN;
            end
        endcase
        if (!rst_n)
            ctl = CTL_RESET;
    end

`ifdef HAZARD_STATS_EN
    logic ev_ld, ev_ms, ev_fl;

    // Stall cycles are those where MEM holds the pipeline outside ERROR,
    // including the RUN cycle that enters the wait.
    assign ev_ms = rst_n && mem_stall && (state == ST_RUN || state == ST_MEM_WAIT);
    assign ev_fl = rst_n && state == ST_RUN && !mem_stall && branch_taken;
    assign ev_ld = rst_n && state == ST_RUN && !mem_stall && !branch_taken && load_use;

    hazard_stall_counter u_ld (.clk(clk), .rst_n(rst_n), .inc(ev_ld), .count(cnt_load_stall));
    hazard_stall_counter u_ms (.clk(clk), .rst_n(rst_n), .inc(ev_ms), .count(cnt_mem_stall));
    hazard_stall_counter u_fl (.clk(clk), .rst_n(rst_n), .inc(ev_fl), .count(cnt_flush));
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 16;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ert;
        logic       mr;
        logic       bt;
        logic       mq;
        logic       mrdy;
    } vin_t;

    typedef struct packed {
        vin_t       in;
        logic [8:0] exp_o;
        logic [1:0] exp_st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       ex_mem_read = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, mem_wb_en, mem_wb_bubble, mem_err;
    logic [1:0] state_o;
`ifdef HAZARD_STATS_EN
    logic [31:0] cnt_load_stall, cnt_mem_stall, cnt_flush;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
`ifdef HAZARD_STATS_EN
        .cnt_load_stall(cnt_load_stall), .cnt_mem_stall(cnt_mem_stall), .cnt_flush(cnt_flush),
`endif
        .state_o(state_o)
    );

    int checks = 0, failures = 0;

    // Reference model: number of frozen cycles spent on the current memory
    // access, a sticky error flag and event tallies.
    int     m_wait = 0;
    bit     m_err = 1'b0;
    longint m_ld = 0, m_ms = 0, m_fl = 0;

    function automatic logic [8:0] outs();
        return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, mem_wb_en, mem_wb_bubble, mem_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vin_t v);
        @(negedge clk);
        rst_n = v.rst_n; id_rs = v.rs; id_rt = v.rt; ex_rt = v.ert;
        ex_mem_read = v.mr; branch_taken = v.bt; mem_req = v.mq; mem_ready = v.mrdy;
        #1;
    endtask

    // Bit order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb, bubble
    task automatic model(input vin_t v, output logic [8:0] eo, output logic [1:0] es);
        logic [7:0] c;
        bit luse;
        es = m_err ? 2'd2 : (m_wait > 0 ? 2'd1 : 2'd0);
        eo[0] = m_err;
        luse = v.mr && v.ert != 0 && (v.ert == v.rs || v.ert == v.rt);
        if (!v.rst_n) begin
            c = 8'b0010_1001;
            m_wait = 0; m_err = 0; m_ld = 0; m_ms = 0; m_fl = 0;
        end else if (m_err)
            c = 8'b0000_0001;
        else if (m_wait > 0 && (!v.mq || v.mrdy)) begin
            c = 8'b1101_0110;
            m_wait = 0;
        end else if (v.mq && !v.mrdy) begin
            c = 8'b0000_0011;
            m_wait++; m_ms++;
            if (m_wait == TO) m_err = 1;
        end else if (v.bt) begin
            c = 8'b1111_1110;
            m_fl++;
        end else if (luse) begin
            c = 8'b0001_1110;
            m_ld++;
        end else
            c = 8'b1101_0110;
        eo[8:1] = c;
    endtask

    task automatic step(input vin_t v, input string nm);
        logic [8:0] eo;
        logic [1:0] es;
        drive(v);
        model(v, eo, es);
        chk({nm, " outs"}, 32'(outs()), 32'(eo));
        chk({nm, " state"}, 32'(state_o), 32'(es));
    endtask

    function automatic vin_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic [4:0] ert,
                                logic mr, logic bt, logic mq, logic mrdy);
        vin_t v;
        v.rst_n = r; v.rs = rs; v.rt = rt; v.ert = ert;
        v.mr = mr; v.bt = bt; v.mq = mq; v.mrdy = mrdy;
        return v;
    endfunction

    vec_t tbl[8];
    vin_t idle, rst, stall, ready;

    initial begin
        logic [8:0] eo;
        logic [1:0] es;
        idle  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        rst   = mk(0, 0, 0, 0, 0, 0, 0, 0);
        stall = mk(1, 0, 0, 0, 0, 0, 1, 0);
        ready = mk(1, 0, 0, 0, 0, 0, 1, 1);
        tbl[0] = '{mk(1, 0, 0, 0, 0, 0, 0, 0), 9'b1101_0110_0, 2'd0};
        tbl[1] = '{mk(1, 5, 3, 5, 1, 0, 0, 0), 9'b0001_1110_0, 2'd0};
        tbl[2] = '{mk(1, 0, 0, 0, 1, 0, 0, 0), 9'b1101_0110_0, 2'd0};
        tbl[3] = '{mk(1, 2, 7, 7, 1, 0, 0, 0), 9'b0001_1110_0, 2'd0};
        tbl[4] = '{mk(1, 5, 5, 5, 0, 0, 0, 0), 9'b1101_0110_0, 2'd0};
        tbl[5] = '{mk(1, 1, 7, 7, 1, 1, 0, 0), 9'b1111_1110_0, 2'd0};
        tbl[6] = '{mk(1, 0, 0, 0, 0, 1, 0, 0), 9'b1111_1110_0, 2'd0};
        tbl[7] = '{mk(1, 4, 4, 4, 1, 0, 1, 1), 9'b0001_1110_0, 2'd0};

        repeat (2) @(posedge clk);
        step(rst, "reset_a");
        step(rst, "reset_b");
        chk("reset state", 32'(state_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].in);
            model(tbl[i].in, eo, es);
            chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(tbl[i].exp_o));
            chk($sformatf("vec%0d state", i), 32'(state_o), 32'(tbl[i].exp_st));
        end
        step(idle, "after_load");
        chk("after_load pc_en", 32'(pc_en), 32'd1);

        for (int i = 0; i < 3; i++) begin
            step(stall, "memwait");
            chk("memwait pc_en", 32'(pc_en), 32'd0);
            chk("memwait bubble", 32'(mem_wb_bubble), 32'd1);
        end
        chk("memwait state", 32'(state_o), 32'd1);
        step(ready, "memready");
        chk("memready pc_en", 32'(pc_en), 32'd1);
        step(idle, "post_ready");
        chk("post_ready state", 32'(state_o), 32'd0);

        for (int i = 0; i < TO; i++) step(stall, "timeout_wait");
        step(ready, "timeout_ready");
        chk("timeout state", 32'(state_o), 32'd2);
        chk("timeout mem_err", 32'(mem_err), 32'd1);
        chk("timeout frozen pc_en", 32'(pc_en), 32'd0);
        step(idle, "error_hold");

        step(rst, "rst_err");
        step(idle, "rst_err_idle");
        for (int i = 0; i < 4; i++) step(stall, "midwait");
        step(rst, "midwait_rst_a");
        chk("midwait rst flush", 32'({if_id_flush, id_ex_flush, mem_wb_bubble}), 32'h7);
        step(rst, "midwait_rst_b");
        chk("midwait rst state", 32'(state_o), 32'd0);
        chk("midwait rst err", 32'(mem_err), 32'd0);
        step(idle, "midwait_idle");

`ifdef HAZARD_STATS_EN
        step(rst, "stats_rst");
        step(mk(1, 5, 0, 5, 1, 0, 0, 0), "stats_ld1");
        step(idle, "stats_i1");
        step(mk(1, 0, 6, 6, 1, 0, 0, 0), "stats_ld2");
        for (int i = 0; i < 3; i++) step(stall, "stats_ms");
        step(ready, "stats_rdy");
        step(mk(1, 0, 0, 0, 0, 1, 0, 0), "stats_br");
        step(idle, "stats_i2");
        chk("cnt_load_stall", cnt_load_stall, 32'd2);
        chk("cnt_mem_stall", cnt_mem_stall, 32'd3);
        chk("cnt_flush", cnt_flush, 32'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            vin_t v;
            v.rst_n = $urandom_range(0, 99) != 0;
            v.rs    = 5'($urandom_range(0, 7));
            v.rt    = 5'($urandom_range(0, 7));
            v.ert   = 5'($urandom_range(0, 7));
            v.mr    = 1'($urandom_range(0, 1));
            v.bt    = $urandom_range(0, 5) == 0;
            v.mq    = 1'($urandom_range(0, 1));
            v.mrdy  = $urandom_range(0, 2) == 0;
            step(v, "random");
        end
        step(idle, "final");
`ifdef HAZARD_STATS_EN
        chk("rand cnt_load_stall", cnt_load_stall, 32'(m_ld));
        chk("rand cnt_mem_stall", cnt_mem_stall, 32'(m_ms));
        chk("rand cnt_flush", cnt_flush, 32'(m_fl));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS32 pipeline. It drives the enable and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves three conditions:
- load-use hazards, by inserting one bubble;
- taken branches, by flushing IF_ID and ID_EX;
- multi-cycle data-memory accesses, through a ready handshake with a timeout watchdog.

Parameters:
SIZE_ADDR, 5, register-address width
MEM_TIMEOUT, 16, max wait cycles for mem_ready before error (≥2)
CNT_W, 5, width of wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous active-low reset
id_rs  in  SIZE_ADDR  rs of instruction in ID
id_rt  in  SIZE_ADDR  rt of instruction in ID
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  SIZE_ADDR  destination of load in EX
branch_taken  in  1  branch resolved taken in EX
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC write enable
if_id_en  out  1  IF_ID load enable
if_id_flush  out  1  IF_ID clear to NOP
id_ex_en  out  1  ID_EX load enable
id_ex_flush  out  1  ID_EX clear to NOP (zero control)
ex_mem_en  out  1  EX_MEM load enable
mem_wb_en  out  1  MEM_WB load enable
mem_wb_bubble  out  1  MEM_WB WB field forced to 0
mem_err  out  1  sticky memory-timeout error
state_o  out  2  current FSM state (debug)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n: it is sampled only on the rising edge of clk.
- Reset outputs:
  - While rst_n=0 is sampled, the FSM goes to RUN, the counter goes to 0 and mem_err goes to 0.
  - In any cycle with rst_n=0, all *_en=0 and if_id_flush = id_ex_flush = mem_wb_bubble = 1.
- Control outputs are combinational from the current state and inputs. The pipeline registers act on them at the same edge, so there is zero latency.
- FSM states (2-bit encoding): RUN=0, MEM_WAIT=1, ERROR=2.
- RUN, default: all *_en=1 and all flush/bubble=0.
- RUN, memory stall (mem_req & ~mem_ready): highest priority.
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
  - mem_wb_en=1 with mem_wb_bubble=1, so no duplicate write-back occurs.
  - Branch and load-use actions are suppressed this cycle. They re-evaluate when the stall releases, because their inputs are held.
  - Next state MEM_WAIT; counter=1.
- RUN, branch_taken (no memory stall): if_id_flush=1 and id_ex_flush=1. All enables stay 1 and the PC loads the branch target.
- RUN, load-use (no memory stall, no branch):
  - Condition: ex_mem_read & ex_rt≠0 & (ex_rt==id_rs | ex_rt==id_rt).
  - Action: pc_en=0, if_id_en=0, id_ex_flush=1; the remaining enables stay 1.
  - This lasts one cycle, because the load advances to MEM.
- Simultaneous branch and load-use: the branch wins, since the ID instruction is discarded.
- MEM_WAIT:
  - If mem_ready=1: outputs equal RUN-default (the pipeline advances this cycle); next state RUN; counter=0.
  - Else if counter==MEM_TIMEOUT-1: next state ERROR and mem_err←1.
  - Else: counter increments and stall outputs are held as in the RUN memory-stall case.
- mem_req dropping in MEM_WAIT is illegal and is treated as mem_ready.
- ERROR: all *_en=0 and mem_wb_bubble=1 (pipeline frozen). mem_err stays 1. Only rst_n exits ERROR.
- Reset mid-wait aborts the wait; mem_req/mem_ready history is ignored.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: adds three 32-bit output ports, cnt_load_stall, cnt_mem_stall and cnt_flush.
  - Each increments by 1 in every cycle its condition drives the pipeline. Memory-stall cycles include the entry cycle.
  - Counters saturate at 0xFFFFFFFF and are cleared by rst_n=0.
- Undefined: the ports and logic are absent; the behaviour is otherwise identical.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - the state encoding constants ST_RUN, ST_MEM_WAIT, ST_ERROR;
  - the register-zero constant;
  - SIZE_ADDR.
- One natural sub-module, hazard_stall_counter: the saturating 32-bit event counter, instantiated three times under HAZARD_STATS_EN.
- The load-use comparator stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle. Expect pc_en=0, if_id_en=0, id_ex_flush=1 that cycle, then all enables 1. With ex_rt=0 instead, expect no stall.
- Branch: branch_taken=1 with a simultaneous load-use (ex_rt=id_rt=7). Expect if_id_flush=id_ex_flush=1, pc_en=1 and no load stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - Expect 3 frozen cycles (pc_en=0, mem_wb_bubble=1) with state_o=1.
  - On the ready cycle, expect enables=1 and state_o=0 next.
- Timeout: mem_req=1, mem_ready stuck at 0. After 16 cycles expect state_o=2 and mem_err=1; the pipeline stays frozen even when mem_ready is later 1.
- Reset mid-wait: rst_n=0 during MEM_WAIT at counter=4. Expect state_o=0, mem_err=0, and all flush=1 while reset is held.
- With HAZARD_STATS_EN: 2 load stalls, 3 memory-stall cycles and 1 branch give cnt_load_stall=2, cnt_mem_stall=3, cnt_flush=1.
